// File: rtl/stream_packer_if.sv
// Bus between the narrow beat stream, the packer and the wide-word consumer.
// The slave modport is the packer's own view; the master modport is the surrounding logic.
interface stream_packer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    logic                        i_valid;
    logic                        o_ready;
    logic [IN_WIDTH-1:0]         in;
    logic                        i_last;
    logic                        o_valid;
    logic                        i_ready;
    logic [IN_WIDTH*RATIO-1:0]   out;
    logic [RATIO-1:0]            o_keep;
    logic                        o_last;

    modport slave (
        input  i_valid, in, i_last, i_ready,
        output o_ready, o_valid, out, o_keep, o_last
    );

    modport master (
        output i_valid, in, i_last, i_ready,
        input  o_ready, o_valid, out, o_keep, o_last
    );
endinterface

// File: rtl/stream_packer.sv
// Narrow-to-wide packer: gathers RATIO input beats into one registered wide word.
// i_last flushes a partial word early; unused lanes are zero and their keep bits are clear.
module stream_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic            clk,
    input  logic            srst,
    stream_packer_if.slave  bus
);
    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [OUT_WIDTH-1:0]   data_reg, data_next;
    logic [RATIO-1:0]       keep_reg, keep_next;
    logic                   last_reg, last_next;
    logic [RATIO-1:0]       lane_hit;
    logic                   ready;
    logic                   beat_acc;
    logic                   complete;

    // One-hot decode of the lane the next accepted beat is written to.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign lane_hit[gi] = (cnt_reg == CNT_W'(gi));
    end

    assign ready    = (state_reg == FILL) | bus.i_ready;
    assign beat_acc = bus.i_valid & ready;
    assign complete = (cnt_reg == CNT_W'(RATIO - 1)) | bus.i_last;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        keep_next  = keep_reg;
        last_next  = last_reg;
        case (state_reg)
            FILL: begin
                if (beat_acc) begin
                    for (int k = 0; k < RATIO; k++) begin
                        if (lane_hit[k]) begin
                            data_next[k*IN_WIDTH +: IN_WIDTH] = bus.in;
                        end
                    end
                    keep_next = keep_reg | lane_hit;
                    if (complete) begin
                        cnt_next   = '0;
                        last_next  = bus.i_last;
                        state_next = HOLD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.i_ready) begin
                    // Word leaves; a beat arriving now seeds lane 0 of a fresh word.
                    data_next  = '0;
                    keep_next  = '0;
                    last_next  = 1'b0;
                    cnt_next   = '0;
                    state_next = FILL;
                    if (beat_acc) begin
                        data_next[IN_WIDTH-1:0] = bus.in;
                        keep_next[0]            = 1'b1;
                        if (complete) begin
                            last_next  = bus.i_last;
                            state_next = HOLD;
                        end else begin
                            cnt_next = CNT_W'(1);
                        end
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= FILL;
            cnt_reg   <= '0;
            data_reg  <= '0;
            keep_reg  <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            keep_reg  <= keep_next;
            last_reg  <= last_next;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = (state_reg == HOLD);
    assign bus.out     = data_reg;
    assign bus.o_keep  = keep_reg;
    assign bus.o_last  = last_reg;
endmodule
